bin2bcd_seq: RTL

Sequential shift-add-3 (double-dabble) converter that sits directly downstream of the two's-complement magnitude/sign stage.
- Takes an unsigned 8-bit magnitude and its sign-segment code.
- Produces three BCD digits (hundreds/tens/units) plus the registered sign code for the seven-segment display decoders.
- Uses a start/busy/done handshake so the display path can sample a stable result.

---
 rtl/bin2bcd_seq_pkg.sv | 28 ++
 rtl/bin2bcd_seq_if.sv | 36 +++
 rtl/bin2bcd_seq_bcd_add3.sv | 13 +
 rtl/bin2bcd_seq.sv | 132 +++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the existing magnitude/sign types of the display path alongside the
// BCD digit type, the blanking code and the converter FSM state encoding.
package bin2bcd_seq_pkg;

  // Signed byte as produced upstream of the magnitude/sign stage.
  typedef logic signed [7:0] int8_t;

  // Sign segment code: OFF shows nothing, TEN lights the minus segment.
  typedef enum logic {
    OFF = 1'b0,
    TEN = 1'b1
  } sgmnt_e;

  // One packed BCD digit.
  typedef logic [3:0] bcd_t;

  // Code driven onto a digit that the display decoder should leave dark.
  localparam bcd_t BCD_BLANK = 4'hF;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bin2bcd_state_e;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the display path and bin2bcd_seq.
//
// Handshake: the requester raises i_start together with i_data/i_sign; the
// request is accepted on a rising clock edge only while the converter is not
// busy (IDLE or DONE), and is silently dropped while o_busy is high. Exactly
// one o_done pulse follows each accepted request, and the result outputs are
// valid from that pulse until the next one. o_busy and o_done are never both
// high. dbg_state mirrors the converter FSM for observation.
import bin2bcd_seq_pkg::*;

interface bin2bcd_seq_if #(
  parameter int DATA_W = 8
);
  logic              i_start;
  logic [DATA_W-1:0] i_data;
  sgmnt_e            i_sign;
  logic              o_busy;
  logic              o_done;
  bcd_t              o_hundreds;
  bcd_t              o_tens;
  bcd_t              o_units;
  sgmnt_e            o_sign;
  bin2bcd_state_e    dbg_state;

  // Requester side (display path / testbench).
  modport master (
    output i_start, i_data, i_sign,
    input  o_busy, o_done, o_hundreds, o_tens, o_units, o_sign, dbg_state
  );

  // Converter side.
  modport slave (
    input  i_start, i_data, i_sign,
    output o_busy, o_done, o_hundreds, o_tens, o_units, o_sign, dbg_state
  );
endinterface

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble digit correction cell: a digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
import bin2bcd_seq_pkg::*;

module bin2bcd_seq_bcd_add3 (
  input  bcd_t digit_i,
  output bcd_t digit_o
);
  // Per-digit 4-bit correction, no carry to neighbouring digits.
  always_comb begin
    digit_o = (digit_i >= 4'd5) ? bcd_t'(digit_i + 4'd3) : digit_i;
  end
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: unsigned DATA_W-bit magnitude to DIGITS
// BCD digits plus the sign code captured with it, one bit per clock.
// Optional build macro: BIN2BCD_BLANK_EN enables leading-zero blanking of
// the hundreds and tens output digits.
import bin2bcd_seq_pkg::*;

module bin2bcd_seq #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input logic              i_clk,
  input logic              i_rst_n,
  bin2bcd_seq_if.slave     bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  bin2bcd_state_e    state_q, state_d;
  logic [DATA_W-1:0] bin_q,   bin_d;
  logic [BCD_W-1:0]  bcd_q,   bcd_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  sgmnt_e            sign_q,  sign_d;
  bcd_t              hund_q,  hund_d;
  bcd_t              tens_q,  tens_d;
  bcd_t              units_q, units_d;
  sgmnt_e            osign_q, osign_d;

  logic [BCD_W-1:0]  bcd_adj;
  logic              accept;
  logic              unused_bcd_msb;

  // Correct every scratch digit before it is shifted.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bin2bcd_seq_bcd_add3 u_add3 (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  // The top bit shifted out of the scratch register is always zero for
  // in-range inputs, so it is deliberately dropped.
  assign unused_bcd_msb = bcd_adj[BCD_W-1];

  // A new request is taken whenever the converter is not mid-conversion.
  assign accept = bus.i_start && (state_q == IDLE || state_q == DONE);

  // Next-state and datapath update; result registers only change on DONE entry.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    units_d = units_q;
    osign_d = osign_q;

    case (state_q)
      IDLE: begin
        if (bus.i_start) state_d = SHIFT;
      end
      SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
        bin_d = {bin_q[DATA_W-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = DONE;
          hund_d  = bcd_d[8 +: 4];
          tens_d  = bcd_d[4 +: 4];
          units_d = bcd_d[0 +: 4];
          osign_d = sign_q;
`ifdef BIN2BCD_BLANK_EN
          if (bcd_d[8 +: 4] == 4'd0) begin
            hund_d = BCD_BLANK;
            if (bcd_d[4 +: 4] == 4'd0) tens_d = BCD_BLANK;
          end
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = bus.i_start ? SHIFT : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      bin_d  = bus.i_data;
      sign_d = bus.i_sign;
      bcd_d  = '0;
      cnt_d  = CNT_W'(DATA_W - 1);
    end
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= OFF;
      hund_q  <= '0;
      tens_q  <= '0;
      units_q <= '0;
      osign_q <= OFF;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      osign_q <= osign_d;
    end
  end

  assign bus.o_busy     = (state_q == SHIFT);
  assign bus.o_done     = (state_q == DONE);
  assign bus.o_hundreds = hund_q;
  assign bus.o_tens     = tens_q;
  assign bus.o_units    = units_q;
  assign bus.o_sign     = osign_q;
  assign bus.dbg_state  = state_q;

endmodule
